// File: rtl/tx_huge_page_sched_if.sv
// DMA read-request channel between the huge-page scheduler and the read engine.
interface tx_huge_page_sched_if;
   logic        rd_req;
   logic [63:0] rd_addr;
   logic [9:0]  rd_qwords;
   logic        rd_ack;
   logic        rd_cpl_done;

   modport master (
      output rd_req, rd_addr, rd_qwords,
      input  rd_ack, rd_cpl_done
   );

   modport slave (
      input  rd_req, rd_addr, rd_qwords,
      output rd_ack, rd_cpl_done
   );
endinterface

// File: rtl/tx_huge_page_sched.sv
// Transmit huge-page scheduler: walks the two driver pages in ping-pong order,
// slices each page into 4 KB-safe DMA reads and hands pages back once drained.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | wait for the active page's status, then capture addr/len
// S_CALC  | size the next chunk, or go free the page when nothing left
// S_REQ   | present the chunk; rd_req gated by the outstanding limit
// S_DRAIN | all chunks acknowledged, wait for completions to reach 0
// S_FREE  | free strobe is high this cycle; count it, flip active page
// S_GAP   | one idle cycle so the freed status has fallen
module tx_huge_page_sched #(
   parameter int MAX_RD_QW       = 64,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                        trn_clk,
   input  logic                        reset,
   input  logic [63:0]                 huge_page_addr_1,
   input  logic [63:0]                 huge_page_addr_2,
   input  logic [31:0]                 huge_page_qwords_1,
   input  logic [31:0]                 huge_page_qwords_2,
   input  logic                        huge_page_status_1,
   input  logic                        huge_page_status_2,
   output logic                        huge_page_free_1,
   output logic                        huge_page_free_2,
   tx_huge_page_sched_if.master        rd,
   output logic                        active_page,
   output logic                        busy,
   output logic [31:0]                 pages_done,
   output logic                        err_cpl_underflow
);

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_DRAIN, S_FREE, S_GAP} state_t;

   localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);
   localparam logic [31:0] MAX_RD  = 32'(MAX_RD_QW);

   state_t      state;
   logic [63:0] cur_addr;
   logic [31:0] remaining;
   logic [3:0]  outstanding;

   logic        ack_hit;
   logic        underflow;
   logic [3:0]  out_nxt;
   logic [9:0]  to_boundary;
   logic [31:0] len;
   logic [31:0] rem_after;
   logic        sel_status;
   logic [63:0] sel_addr;
   logic [31:0] sel_qwords;

   // Next outstanding count, chunk sizing and active-page selection.
   always_comb begin
      ack_hit   = rd.rd_req & rd.rd_ack;
      underflow = 1'b0;
      out_nxt   = outstanding;
      if (ack_hit && !rd.rd_cpl_done) begin
         out_nxt = outstanding + 4'd1;
      end else if (!ack_hit && rd.rd_cpl_done) begin
         if (outstanding == 4'd0) underflow = 1'b1;
         else                     out_nxt   = outstanding - 4'd1;
      end

      // Qwords left before the next 4 KB boundary: 1..512.
      to_boundary = 10'd512 - {1'b0, cur_addr[11:3]};
      len = remaining;
      if (MAX_RD < len)                 len = MAX_RD;
      if ({22'd0, to_boundary} < len)   len = {22'd0, to_boundary};

      rem_after  = remaining - {22'd0, rd.rd_qwords};
      sel_status = active_page ? huge_page_status_2 : huge_page_status_1;
      sel_addr   = active_page ? huge_page_addr_2   : huge_page_addr_1;
      sel_qwords = active_page ? huge_page_qwords_2 : huge_page_qwords_1;
   end

   // Scheduler FSM with all outputs registered.
   always_ff @(posedge trn_clk) begin
      if (reset) begin
         state             <= S_IDLE;
         active_page       <= 1'b0;
         rd.rd_req         <= 1'b0;
         rd.rd_addr        <= 64'd0;
         rd.rd_qwords      <= 10'd0;
         huge_page_free_1  <= 1'b0;
         huge_page_free_2  <= 1'b0;
         outstanding       <= 4'd0;
         pages_done        <= 32'd0;
         err_cpl_underflow <= 1'b0;
         busy              <= 1'b0;
         cur_addr          <= 64'd0;
         remaining         <= 32'd0;
      end else begin
         outstanding      <= out_nxt;
         huge_page_free_1 <= 1'b0;
         huge_page_free_2 <= 1'b0;
         if (underflow) err_cpl_underflow <= 1'b1;

         case (state)
            S_IDLE: begin
               if (sel_status) begin
                  cur_addr  <= sel_addr;
                  remaining <= sel_qwords;
                  busy      <= 1'b1;
                  state     <= S_CALC;
               end
            end
            S_CALC: begin
               if (remaining == 32'd0) begin
                  huge_page_free_1 <= ~active_page;
                  huge_page_free_2 <= active_page;
                  state            <= S_FREE;
               end else begin
                  rd.rd_addr   <= cur_addr;
                  rd.rd_qwords <= len[9:0];
                  rd.rd_req    <= (out_nxt < MAX_OUT);
                  state        <= S_REQ;
               end
            end
            S_REQ: begin
               if (ack_hit) begin
                  rd.rd_req <= 1'b0;
                  cur_addr  <= cur_addr + {51'd0, rd.rd_qwords, 3'b000};
                  remaining <= rem_after;
                  state     <= (rem_after != 32'd0) ? S_CALC : S_DRAIN;
               end else begin
                  rd.rd_req <= (out_nxt < MAX_OUT);
               end
            end
            S_DRAIN: begin
               if (outstanding == 4'd0) begin
                  huge_page_free_1 <= ~active_page;
                  huge_page_free_2 <= active_page;
                  state            <= S_FREE;
               end
            end
            S_FREE: begin
               pages_done  <= pages_done + 32'd1;
               active_page <= ~active_page;
               state       <= S_GAP;
            end
            S_GAP: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_huge_page_sched.sv
// Bench for tx_huge_page_sched: directed scenarios plus randomized pages
// checked against a chunk-list model of the page-splitting rules.
module tb_tx_huge_page_sched;

   localparam int MAX_OUT = 4;
   localparam int MAX_RD  = 64;

   logic        trn_clk = 1'b0;
   logic        reset;
   logic [63:0] huge_page_addr_1, huge_page_addr_2;
   logic [31:0] huge_page_qwords_1, huge_page_qwords_2;
   logic        huge_page_status_1, huge_page_status_2;
   logic        huge_page_free_1, huge_page_free_2;
   logic        active_page, busy;
   logic [31:0] pages_done;
   logic        err_cpl_underflow;

   tx_huge_page_sched_if rif();

   tx_huge_page_sched #(.MAX_RD_QW(MAX_RD), .MAX_OUTSTANDING(MAX_OUT)) dut (
      .trn_clk            (trn_clk),
      .reset              (reset),
      .huge_page_addr_1   (huge_page_addr_1),
      .huge_page_addr_2   (huge_page_addr_2),
      .huge_page_qwords_1 (huge_page_qwords_1),
      .huge_page_qwords_2 (huge_page_qwords_2),
      .huge_page_status_1 (huge_page_status_1),
      .huge_page_status_2 (huge_page_status_2),
      .huge_page_free_1   (huge_page_free_1),
      .huge_page_free_2   (huge_page_free_2),
      .rd                 (rif),
      .active_page        (active_page),
      .busy               (busy),
      .pages_done         (pages_done),
      .err_cpl_underflow  (err_cpl_underflow)
   );

   always #5 trn_clk = ~trn_clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          tb_out  = 0;
   logic [31:0] exp_pages = 32'd0;
   logic        exp_active = 1'b0;
   logic [63:0] q_addr[$];
   int          q_len[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
         $error("check %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(negedge trn_clk);
   endtask

   // Expected chunk list: min(remaining, MAX_RD, qwords to next 4 KB boundary).
   task automatic build(input logic [63:0] a_in, input logic [31:0] qw);
      logic [63:0] a;
      int rem, len, b;
      a = a_in;
      rem = int'(qw);
      q_addr.delete();
      q_len.delete();
      while (rem > 0) begin
         b = 512 - int'(a[11:3]);
         len = rem;
         if (len > MAX_RD) len = MAX_RD;
         if (len > b) len = b;
         q_addr.push_back(a);
         q_len.push_back(len);
         a = a + 64'(len * 8);
         rem = rem - len;
      end
   endtask

   task automatic set_page(input logic pg, input logic [63:0] a, input logic [31:0] qw);
      if (pg == 1'b0) begin
         huge_page_addr_1 = a; huge_page_qwords_1 = qw; huge_page_status_1 = 1'b1;
      end else begin
         huge_page_addr_2 = a; huge_page_qwords_2 = qw; huge_page_status_2 = 1'b1;
      end
   endtask

   task automatic drop_status(input logic pg);
      if (pg == 1'b0) huge_page_status_1 = 1'b0;
      else            huge_page_status_2 = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      huge_page_status_1 = 1'b0;
      huge_page_status_2 = 1'b0;
      rif.rd_ack = 1'b0;
      rif.rd_cpl_done = 1'b0;
      step(); step();
      reset = 1'b0;
      tb_out = 0;
      exp_pages = 32'd0;
      exp_active = 1'b0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 50 && !rif.rd_req; i++) step();
      chk("req_wait", 64'(rif.rd_req), 64'd1);
   endtask

   // Serve one page on the expected active page with random ack/cpl timing.
   task automatic serve(input logic [63:0] a, input logic [31:0] qw,
                        input int ack_pct, input int cpl_pct, input bit chk_lat);
      logic pg;
      bit   freed, ack, cpl;
      int   first_req, last_cpl, free_cyc, tb_prev;
      pg = exp_active;
      freed = 1'b0; first_req = -1; last_cpl = -1; free_cyc = -1;
      chk("active_before", 64'(active_page), 64'(pg));
      build(a, qw);
      set_page(pg, a, qw);
      for (int i = 0; i < 3000 && !freed; i++) begin
         tb_prev = tb_out;
         ack = 1'b0;
         cpl = 1'b0;
         if (tb_prev == MAX_OUT) chk("req_gated", 64'(rif.rd_req), 64'd0);
         if (rif.rd_req) begin
            if (first_req < 0) first_req = i;
            if (q_len.size() == 0) begin
               chk("extra_req", 64'd1, 64'd0);
            end else begin
               chk("rd_addr", rif.rd_addr, q_addr[0]);
               chk("rd_qwords", 64'(rif.rd_qwords), 64'(q_len[0]));
               ack = ($urandom_range(99) < 32'(ack_pct));
               if (ack) begin
                  void'(q_addr.pop_front());
                  void'(q_len.pop_front());
                  tb_out++;
               end
            end
         end
         if (huge_page_free_1 || huge_page_free_2) begin
            chk("free_page", 64'({huge_page_free_2, huge_page_free_1}), pg ? 64'd2 : 64'd1);
            chk("chunks_left", 64'(q_len.size()), 64'd0);
            chk("out_at_free", 64'(tb_out), 64'd0);
            drop_status(pg);
            freed = 1'b1;
            free_cyc = i;
         end
         if (tb_prev > 0 && $urandom_range(99) < 32'(cpl_pct)) begin
            cpl = 1'b1;
            tb_out--;
            last_cpl = i;
         end
         rif.rd_ack = ack;
         rif.rd_cpl_done = cpl;
         step();
      end
      rif.rd_ack = 1'b0;
      rif.rd_cpl_done = 1'b0;
      chk("page_freed", 64'(freed), 64'd1);
      if (chk_lat) chk("req_latency", 64'(first_req), 64'd2);
      if (qw != 32'd0) chk("free_latency", 64'(free_cyc - last_cpl), 64'd2);
      step(); step();
      exp_pages = exp_pages + 32'd1;
      exp_active = ~exp_active;
      chk("pages_done", 64'(pages_done), 64'(exp_pages));
      chk("active_after", 64'(active_page), 64'(exp_active));
   endtask

   initial begin
      int          acks, any_act;
      logic [63:0] ra;
      logic [31:0] rq;

      huge_page_addr_1 = 64'd0; huge_page_addr_2 = 64'd0;
      huge_page_qwords_1 = 32'd0; huge_page_qwords_2 = 32'd0;
      step();
      do_reset();

      // Reset state.
      chk("rst_rd_req", 64'(rif.rd_req), 64'd0);
      chk("rst_rd_addr", rif.rd_addr, 64'd0);
      chk("rst_rd_qwords", 64'(rif.rd_qwords), 64'd0);
      chk("rst_free", 64'({huge_page_free_2, huge_page_free_1}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_active", 64'(active_page), 64'd0);
      chk("rst_pages", 64'(pages_done), 64'd0);
      chk("rst_err", 64'(err_cpl_underflow), 64'd0);

      // Only page 2 ready: strict ping-pong means nothing happens.
      set_page(1'b1, 64'h0000_0000_4000_0100, 32'd40);
      any_act = 0;
      for (int i = 0; i < 12; i++) begin
         if (rif.rd_req || busy || huge_page_free_1 || huge_page_free_2) any_act = 1;
         step();
      end
      chk("no_wait_p2", 64'(any_act), 64'd0);

      // Zero-length page 1, then the waiting page 2.
      serve(64'h0000_0000_5000_0000, 32'd0, 100, 50, 1'b0);
      serve(64'h0000_0000_4000_0100, 32'd40, 70, 50, 1'b0);

      // Two full-size chunks with request latency check; then 4 KB crossing.
      serve(64'h0000_0000_1000_0000, 32'd128, 100, 60, 1'b1);
      serve(64'h0000_0000_2000_0040, 32'd100, 60, 40, 1'b0);
      serve(64'h0000_0000_1000_0FC0, 32'd20, 80, 50, 1'b1);

      // Randomized pages.
      for (int p = 0; p < 12; p++) begin
         ra = {$urandom, $urandom} & ~64'h7;
         if ($urandom_range(1) == 0) ra[11:3] = 9'(9'd511 - 9'($urandom_range(20)));
         rq = 32'($urandom_range(300));
         serve(ra, rq, 30 + int'($urandom_range(70)), 20 + int'($urandom_range(70)), 1'b0);
      end

      // Same-cycle ack and completion leave outstanding unchanged.
      set_page(exp_active, 64'h0000_0000_2000_0000, 32'd128);
      wait_req();
      chk("sc_addr0", rif.rd_addr, 64'h0000_0000_2000_0000);
      rif.rd_ack = 1'b1; step(); rif.rd_ack = 1'b0;
      wait_req();
      chk("sc_addr1", rif.rd_addr, 64'h0000_0000_2000_0200);
      rif.rd_ack = 1'b1; rif.rd_cpl_done = 1'b1; step();
      rif.rd_ack = 1'b0; rif.rd_cpl_done = 1'b0;
      any_act = 0;
      for (int i = 0; i < 5; i++) begin
         if (huge_page_free_1 || huge_page_free_2) any_act = 1;
         step();
      end
      chk("sc_no_early_free", 64'(any_act), 64'd0);
      chk("sc_no_err", 64'(err_cpl_underflow), 64'd0);
      rif.rd_cpl_done = 1'b1; step(); rif.rd_cpl_done = 1'b0; step();
      chk("sc_free", 64'({huge_page_free_2, huge_page_free_1}), exp_active ? 64'd2 : 64'd1);
      drop_status(exp_active);
      exp_active = ~exp_active;
      exp_pages = exp_pages + 32'd1;
      step(); step();
      chk("sc_pages", 64'(pages_done), 64'(exp_pages));

      // Completion with nothing outstanding: sticky underflow.
      rif.rd_cpl_done = 1'b1; step(); rif.rd_cpl_done = 1'b0; step();
      chk("uf_set", 64'(err_cpl_underflow), 64'd1);
      for (int i = 0; i < 4; i++) step();
      chk("uf_sticky", 64'(err_cpl_underflow), 64'd1);

      // Outstanding limit: immediate acks, no completions.
      set_page(exp_active, 64'h0000_0000_3000_0000, 32'd512);
      acks = 0;
      for (int i = 0; i < 40; i++) begin
         rif.rd_ack = rif.rd_req;
         if (rif.rd_req) acks++;
         step();
      end
      rif.rd_ack = 1'b0;
      chk("lim_acks", 64'(acks), 64'(MAX_OUT));
      chk("lim_req_low", 64'(rif.rd_req), 64'd0);
      rif.rd_cpl_done = 1'b1; step(); rif.rd_cpl_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         rif.rd_ack = rif.rd_req;
         if (rif.rd_req) acks++;
         step();
      end
      rif.rd_ack = 1'b0;
      chk("lim_release_one", 64'(acks), 64'(MAX_OUT + 1));
      chk("lim_req_low2", 64'(rif.rd_req), 64'd0);
      rif.rd_cpl_done = 1'b1; step(); rif.rd_cpl_done = 1'b0; step(); step();
      chk("lim_req_3out", 64'(rif.rd_req), 64'd1);

      // Reset in REQ with 3 outstanding.
      reset = 1'b1;
      huge_page_status_1 = 1'b0;
      huge_page_status_2 = 1'b0;
      step();
      chk("mid_rd_req", 64'(rif.rd_req), 64'd0);
      chk("mid_rd_addr", rif.rd_addr, 64'd0);
      chk("mid_rd_qwords", 64'(rif.rd_qwords), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_pages", 64'(pages_done), 64'd0);
      chk("mid_err", 64'(err_cpl_underflow), 64'd0);
      chk("mid_active", 64'(active_page), 64'd0);
      reset = 1'b0;
      tb_out = 0;
      exp_pages = 32'd0;
      exp_active = 1'b0;
      rif.rd_cpl_done = 1'b1; step(); rif.rd_cpl_done = 1'b0; step();
      chk("late_cpl_err", 64'(err_cpl_underflow), 64'd1);

      // Service restarts at page 1.
      do_reset();
      serve(64'h0000_0000_6000_0E00, 32'd90, 80, 60, 1'b1);
      serve(64'h0000_0000_7000_0000, 32'd70, 80, 60, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
